c_slice_serializer: RTL and testbench

Downstream consumer of the 9-slice inverter/OAI222 output stage. It captures the 36 meaningful bits of the 41-bit C result bus under a valid/ready handshake. It then emits the word as nine 4-bit slice nibbles, one per accepted output beat, with a running XOR checksum and a completed-word counter. It lets the bench and the downstream scan/trace logic observe the per-slice results of the flattened netlist without a 41-bit wide path.

---
 rtl/c_slice_serializer.sv | 121 ++++++++++++
 tb/tb_c_slice_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_slice_serializer.sv
// ============================================================================
//  Module  : c_slice_serializer
//  Brief   : Captures the 36 live bits of the C result bus and emits them as
//            nine 4-bit slice nibbles with a running XOR checksum and word count.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module c_slice_serializer #(
    parameter int DW     = 41,
    parameter int NSLICE = 9,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_nibble,
    output logic [3:0]      out_idx,
    output logic            out_last,
    output logic [3:0]      out_chk,
    output logic [CNTW-1:0] word_cnt
);

    localparam int         C_HW   = 4 * NSLICE;
    localparam logic [3:0] C_LAST = 4'(NSLICE - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [C_HW-1:0]   hold_q,  hold_d;
    logic [3:0]        idx_q,   idx_d;
    logic [3:0]        chk_q,   chk_d;
    logic [CNTW-1:0]   cnt_q,   cnt_d;

    logic [3:0]        w_slice [NSLICE];
    logic              w_beat;
    logic              w_at_last;

    // Upper C-bus bits carry no slice data; only reduced here so they are consumed.
    logic              unused_hi_bits;
    assign unused_hi_bits = ^in_data[DW-1:C_HW];

    generate
        for (genvar k = 0; k < NSLICE; k++) begin : g_slice
            assign w_slice[k] = hold_q[4*k +: 4];
        end
    endgenerate

    assign w_at_last  = (idx_q == C_LAST);
    assign out_valid  = (state_q == ST_SHIFT);
    assign out_nibble = w_slice[idx_q];
    assign out_idx    = idx_q;
    assign out_last   = out_valid && w_at_last;
    assign out_chk    = chk_q ^ out_nibble;
    assign word_cnt   = cnt_q;
    assign w_beat     = out_valid && out_ready;
    assign in_ready   = (state_q == ST_IDLE) || (w_beat && out_last);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data[C_HW-1:0];
                    idx_d   = 4'd0;
                    chk_d   = 4'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_beat) begin
                    if (!w_at_last) begin
                        idx_d = idx_q + 4'd1;
                        chk_d = chk_q ^ out_nibble;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                        idx_d = 4'd0;
                        // Back-to-back load keeps the output stream gap-free.
                        if (in_valid) begin
                            hold_d = in_data[C_HW-1:0];
                            chk_d  = 4'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            idx_q   <= 4'd0;
            chk_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_c_slice_serializer.sv
// ============================================================================
//  Module  : tb_c_slice_serializer
//  Brief   : Directed self-checking bench for c_slice_serializer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_c_slice_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [40:0] in_data;
    logic        out_ready;

    logic        in_ready, out_valid, out_last;
    logic [3:0]  out_nibble, out_idx, out_chk;
    logic [15:0] word_cnt;

    logic        in_ready4, out_valid4, out_last4;
    logic [3:0]  out_nibble4, out_idx4, out_chk4;
    logic [3:0]  word_cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    c_slice_serializer #(.DW(41), .NSLICE(9), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_nibble(out_nibble), .out_idx(out_idx), .out_last(out_last),
        .out_chk(out_chk), .word_cnt(word_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used for the wrap check.
    c_slice_serializer #(.DW(41), .NSLICE(9), .CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_nibble(out_nibble4), .out_idx(out_idx4), .out_last(out_last4),
        .out_chk(out_chk4), .word_cnt(word_cnt4)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({out_valid, in_ready, out_last} !== 3'b010) begin
            errors++;
            $display("FAIL reset_flags: got v/rdy/last=%b expected 010", {out_valid, in_ready, out_last});
        end
        checks++;
        if ({out_nibble, out_idx, out_chk, word_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL reset_values: got nib=%h idx=%h chk=%h cnt=%h expected all 0",
                     out_nibble, out_idx, out_chk, word_cnt);
        end
    endtask

    task automatic test_single_word;
        in_data = 41'h0_876543210; in_valid = 1'b1; out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL single_in_ready_idle: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if ({out_valid, out_nibble, out_idx, out_last} !== {1'b1, 4'(k), 4'(k), (k == 8)}) begin
                errors++;
                $display("FAIL single_beat%0d: got v=%b nib=%h idx=%h last=%b expected 1 %h %h %b",
                         k, out_valid, out_nibble, out_idx, out_last, 4'(k), 4'(k), (k == 8));
            end
            checks++;
            if (in_ready !== (k == 8)) begin
                errors++; $display("FAIL single_in_ready%0d: got %b expected %b", k, in_ready, (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (out_chk !== 4'h8) begin
                    errors++; $display("FAIL single_chk: got %h expected 8", out_chk);
                end
            end
            step();
        end
        checks++;
        if ({out_valid, in_ready, word_cnt} !== {1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL single_after: got v=%b rdy=%b cnt=%0d expected 0 1 1", out_valid, in_ready, word_cnt);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        in_data = 41'h0_FFFFFFFFF; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = 41'h0;
        for (int b = 0; b < 18; b++) begin
            if (b == 9) in_valid = 1'b0;
            checks++;
            if ({out_valid, out_nibble, out_idx} !== {1'b1, (b < 9) ? 4'hF : 4'h0, 4'(b % 9)}) begin
                errors++;
                $display("FAIL b2b_beat%0d: got v=%b nib=%h idx=%h expected 1 %h %h",
                         b, out_valid, out_nibble, out_idx, (b < 9) ? 4'hF : 4'h0, 4'(b % 9));
            end
            if (b == 8 || b == 17) begin
                checks++;
                if (out_chk !== ((b == 8) ? 4'hF : 4'h0)) begin
                    errors++;
                    $display("FAIL b2b_chk%0d: got %h expected %h", b, out_chk, (b == 8) ? 4'hF : 4'h0);
                end
            end
            step();
        end
        checks++;
        if ({out_valid, word_cnt} !== {1'b0, 16'd2}) begin
            errors++; $display("FAIL b2b_after: got v=%b cnt=%0d expected 0 2", out_valid, word_cnt);
        end
    endtask

    task automatic test_stall;
        in_data = 41'h0_876543210; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({out_valid, in_ready, out_nibble, out_idx, out_chk} !== {1'b1, 1'b0, 4'h4, 4'h4, 4'h4}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b rdy=%b nib=%h idx=%h chk=%h expected 1 0 4 4 4",
                         s, out_valid, in_ready, out_nibble, out_idx, out_chk);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_nibble, out_idx, out_chk} !== {4'h5, 4'h5, 4'h1}) begin
            errors++;
            $display("FAIL stall_resume: got nib=%h idx=%h chk=%h expected 5 5 1", out_nibble, out_idx, out_chk);
        end
        repeat (4) step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_drain: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_xbits;
        in_data = {5'bxxxxx, 36'h123456789}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if ($isunknown({in_ready, out_valid, out_nibble, out_idx, out_last, out_chk, word_cnt}) !== 1'b0) begin
                errors++;
                $display("FAIL xbits_unknown%0d: got nib=%h chk=%h cnt=%h expected no X", k, out_nibble, out_chk, word_cnt);
            end
            checks++;
            if (out_nibble !== 4'(9 - k)) begin
                errors++; $display("FAIL xbits_nib%0d: got %h expected %h", k, out_nibble, 4'(9 - k));
            end
            if (k == 8) begin
                checks++;
                if (out_chk !== 4'h1) begin
                    errors++; $display("FAIL xbits_chk: got %h expected 1", out_chk);
                end
            end
            step();
        end
        in_data = '0;
    endtask

    task automatic test_reset_midword;
        in_data = 41'h0_876543210; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (out_idx !== 4'h5) begin
            errors++; $display("FAIL midrst_pre_idx: got %h expected 5", out_idx);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_nibble, out_idx, out_last, out_chk, word_cnt}
            !== {1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 16'd0}) begin
            errors++;
            $display("FAIL midrst_async: got v=%b rdy=%b nib=%h idx=%h last=%b chk=%h cnt=%0d expected 0 1 0 0 0 0 0",
                     out_valid, in_ready, out_nibble, out_idx, out_last, out_chk, word_cnt);
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: got v=%b expected 0", out_valid);
        end
        in_data = 41'h0_123456789; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_idx, out_nibble, word_cnt} !== {1'b1, 4'h0, 4'h9, 16'd0}) begin
            errors++;
            $display("FAIL midrst_restart: got v=%b idx=%h nib=%h cnt=%0d expected 1 0 9 0",
                     out_valid, out_idx, out_nibble, word_cnt);
        end
        repeat (9) step();
        checks++;
        if (word_cnt !== 16'd1) begin
            errors++; $display("FAIL midrst_cnt: got %0d expected 1", word_cnt);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        in_data = 41'h0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        for (int w = 0; w < 16; w++) begin
            repeat (8) step();
            if (w == 15) in_valid = 1'b0;
            step();
            checks++;
            if (word_cnt4 !== 4'((w + 1) % 16)) begin
                errors++; $display("FAIL wrap_cnt%0d: got %0d expected %0d", w, word_cnt4, (w + 1) % 16);
            end
            checks++;
            if (out_valid4 !== (w != 15)) begin
                errors++; $display("FAIL wrap_valid%0d: got %b expected %b", w, out_valid4, (w != 15));
            end
        end
        checks++;
        if (word_cnt !== 16'd16) begin
            errors++; $display("FAIL wrap_wide_cnt: got %0d expected 16", word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_xbits();
        test_reset_midword();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
